// File: rtl/byte_striping_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_striping_pkg
//  Description : Shared encodings and helpers for the parametrised byte
//                striper: laneMode codes, lane-count decode, default pad.
//  Revision    : 1.0 - initial release
// ============================================================================
package byte_striping_pkg;

    // laneMode encoding: number of active lanes requested
    localparam logic [1:0] MODE_1L = 2'd0;
    localparam logic [1:0] MODE_2L = 2'd1;
    localparam logic [1:0] MODE_4L = 2'd2;
    localparam logic [1:0] MODE_8L = 2'd3;

    // Symbol used for flushed or unused lane slots
    localparam logic [7:0] DEFAULT_PAD_WORD = 8'hBC;

    // Decode a laneMode into a lane count, clipped to the physical lane count.
    // The result fits 4 bits because at most 8 lanes exist.
    function automatic logic [3:0] mode2lanes(input logic [1:0] mode, input int num_lanes);
        logic [3:0] n;
        n = 4'd1 << mode;
        if (int'(n) > num_lanes) begin
            n = num_lanes[3:0];
        end
        return n;
    endfunction

endpackage : byte_striping_pkg
`default_nettype wire

// File: rtl/byte_striping_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : byte_striping_ctrl
//  Description : Slot counter, per-group lane-count latch and emit/flush
//                decision for the byte striper.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_striping_ctrl
    import byte_striping_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LW        = $clog2(NUM_LANES + 1),
    parameter int IW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                 clk1Mhz,
    input  logic                 reset,
    input  logic                 laneVLD,
    input  logic                 flushIN,
    input  logic [1:0]           laneMode,
    output logic                 wrEn,
    output logic [IW-1:0]        wrIdx,
    output logic                 emit,
    output logic [NUM_LANES-1:0] realMask
);

    localparam logic [LW-1:0] C_FULL  = LW'(NUM_LANES);
    localparam logic [LW-1:0] C_ONE   = LW'(1);
    localparam logic [LW-1:0] C_ZERO  = '0;

    logic [LW-1:0] r_idx;
    logic [LW-1:0] r_active_n;
    logic [LW-1:0] w_mode_lanes;
    logic [LW-1:0] w_cur_n;
    logic [LW-1:0] w_idx_after;
    logic          w_group_start;
    logic          w_complete;
    logic          w_flush_emit;

    // Decode the group size: a new group takes laneMode, an open group keeps its latch
    always_comb begin
        w_mode_lanes  = LW'(mode2lanes(laneMode, NUM_LANES));
        w_group_start = laneVLD && (r_idx == C_ZERO);
        w_cur_n       = w_group_start ? w_mode_lanes : r_active_n;
        w_idx_after   = r_idx + (laneVLD ? C_ONE : C_ZERO);
        w_complete    = laneVLD && (r_idx == (w_cur_n - C_ONE));
        w_flush_emit  = flushIN && (w_idx_after != C_ZERO);
        wrEn          = laneVLD;
        wrIdx         = r_idx[IW-1:0];
        emit          = w_complete || w_flush_emit;
    end

    // Real slots are exactly those filled so far, including a same-cycle accept;
    // on a full group this equals the active lane count.
    always_comb begin
        realMask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            realMask[k] = (LW'(k) < w_idx_after);
        end
    end

    // Slot counter and per-group lane-count latch
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            r_idx      <= C_ZERO;
            r_active_n <= C_FULL;
        end else begin
            if (w_group_start) begin
                r_active_n <= w_mode_lanes;
            end
            r_idx <= emit ? C_ZERO : w_idx_after;
        end
    end

endmodule : byte_striping_ctrl
`default_nettype wire

// File: rtl/byte_striping_param.sv
`default_nettype none
// ============================================================================
//  Module      : byte_striping_param
//  Description : Round-robin striping of a W-bit word stream across
//                NUM_LANES lanes, with runtime lane count, pad flush and a
//                group counter. Outputs are registered; one-cycle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_striping_param
    import byte_striping_pkg::*;
#(
    parameter int             W         = 8,
    parameter int             NUM_LANES = 4,
    parameter logic [W-1:0]   PAD_WORD  = DEFAULT_PAD_WORD,
    parameter int             CNT_W     = 8
) (
    input  logic                   clk1Mhz,
    input  logic                   reset,
    input  logic [W-1:0]           byteStripingIN,
    input  logic                   laneVLD,
    input  logic                   flushIN,
    input  logic [1:0]             laneMode,
    output logic [NUM_LANES*W-1:0] stripedLanes,
    output logic [NUM_LANES-1:0]   laneValidOut,
    output logic                   byteStripingVLD,
    output logic [CNT_W-1:0]       groupCnt
);

    localparam int IW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic                 w_wr_en;
    logic [IW-1:0]        w_wr_idx;
    logic                 w_emit;
    logic [NUM_LANES-1:0] w_real_mask;

    logic [W-1:0]         r_stage [NUM_LANES];
    logic [W-1:0]         r_lanes [NUM_LANES];
    logic [W-1:0]         w_next_lane [NUM_LANES];
    logic [NUM_LANES-1:0] r_valid;
    logic                 r_vld;
    logic [CNT_W-1:0]     r_cnt;

    byte_striping_ctrl #(
        .NUM_LANES (NUM_LANES),
        .IW        (IW)
    ) u_ctrl (
        .clk1Mhz  (clk1Mhz),
        .reset    (reset),
        .laneVLD  (laneVLD),
        .flushIN  (flushIN),
        .laneMode (laneMode),
        .wrEn     (w_wr_en),
        .wrIdx    (w_wr_idx),
        .emit     (w_emit),
        .realMask (w_real_mask)
    );

    // Per-lane emit value: the word arriving this cycle bypasses staging so the
    // group is presented at the same edge as its last accept.
    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
            assign w_next_lane[k] = !w_real_mask[k]                    ? PAD_WORD       :
                                    (w_wr_en && (w_wr_idx == IW'(k)))  ? byteStripingIN :
                                                                         r_stage[k];
            assign stripedLanes[k*W +: W] = r_lanes[k];
        end
    endgenerate

    // Staging buffer: each accepted word lands in its slot
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_stage[k] <= '0;
            end
        end else if (w_wr_en) begin
            r_stage[w_wr_idx] <= byteStripingIN;
        end
    end

    // Output registers: load on emit, otherwise hold; strobe lasts one cycle
    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_lanes[k] <= '0;
            end
            r_valid <= '0;
            r_vld   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_vld <= w_emit;
            if (w_emit) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    r_lanes[k] <= w_next_lane[k];
                end
                r_valid <= w_real_mask;
                r_cnt   <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign laneValidOut    = r_valid;
    assign byteStripingVLD = r_vld;
    assign groupCnt        = r_cnt;

endmodule : byte_striping_param
`default_nettype wire

// File: tb/tb_byte_striping_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_byte_striping_param
//  Description : Directed self-checking bench for byte_striping_param
//                (W=8, NUM_LANES=4, PAD=BC, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_striping_param;

    logic        clk1Mhz = 1'b0;
    logic        reset;
    logic [7:0]  byteStripingIN;
    logic        laneVLD;
    logic        flushIN;
    logic [1:0]  laneMode;
    logic [31:0] stripedLanes;
    logic [3:0]  laneValidOut;
    logic        byteStripingVLD;
    logic [1:0]  groupCnt;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    byte_striping_param #(
        .W         (8),
        .NUM_LANES (4),
        .PAD_WORD  (8'hBC),
        .CNT_W     (2)
    ) dut (
        .clk1Mhz         (clk1Mhz),
        .reset           (reset),
        .byteStripingIN  (byteStripingIN),
        .laneVLD         (laneVLD),
        .flushIN         (flushIN),
        .laneMode        (laneMode),
        .stripedLanes    (stripedLanes),
        .laneValidOut    (laneValidOut),
        .byteStripingVLD (byteStripingVLD),
        .groupCnt        (groupCnt)
    );

    always #5 clk1Mhz = ~clk1Mhz;

    // One clock: apply inputs, take the edge, settle 1 time unit past it
    task automatic step(input logic v, input logic [7:0] d, input logic f,
                        input logic [1:0] m, input logic r);
        laneVLD        = v;
        byteStripingIN = d;
        flushIN        = f;
        laneMode       = m;
        reset          = r;
        @(posedge clk1Mhz);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 8'h5A, 1'b1, 2'd2, 1'b1);
        step(1'b1, 8'h5A, 1'b0, 2'd2, 1'b1);
        exp_cnt = 0;
        n_cmp++; if (stripedLanes !== 32'h0) begin n_fail++; $display("FAIL reset_lanes: got %h want %h", stripedLanes, 32'h0); end
        n_cmp++; if (laneValidOut !== 4'h0) begin n_fail++; $display("FAIL reset_mask: got %b want %b", laneValidOut, 4'h0); end
        n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", byteStripingVLD); end
        n_cmp++; if (groupCnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", groupCnt); end
    endtask

    task automatic test_full_group();
        logic [7:0] w [4];
        w[0] = 8'h00; w[1] = 8'h0F; w[2] = 8'hF0; w[3] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, w[i], 1'b0, 2'd2, 1'b0);
            if (i < 3) begin
                n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL full_early_vld[%0d]: got %b want 0", i, byteStripingVLD); end
            end
        end
        exp_cnt++;
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL full_vld: got %b want 1", byteStripingVLD); end
        n_cmp++; if (stripedLanes !== 32'hFFF00F00) begin n_fail++; $display("FAIL full_lanes: got %h want %h", stripedLanes, 32'hFFF00F00); end
        n_cmp++; if (laneValidOut !== 4'b1111) begin n_fail++; $display("FAIL full_mask: got %b want 1111", laneValidOut); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL full_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
        step(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
        n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL full_vld_drop: got %b want 0", byteStripingVLD); end
        n_cmp++; if (stripedLanes !== 32'hFFF00F00) begin n_fail++; $display("FAIL full_hold: got %h want %h", stripedLanes, 32'hFFF00F00); end
    endtask

    task automatic test_gaps();
        logic [7:0] d [7];
        logic       v [7];
        d[0]=8'h11; v[0]=1; d[1]=8'h00; v[1]=0; d[2]=8'h22; v[2]=1; d[3]=8'h00; v[3]=0;
        d[4]=8'h00; v[4]=0; d[5]=8'h33; v[5]=1; d[6]=8'h44; v[6]=1;
        for (int i = 0; i < 7; i++) begin
            step(v[i], d[i], 1'b0, 2'd2, 1'b0);
            if (i < 6) begin
                n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL gaps_early_vld[%0d]: got %b want 0", i, byteStripingVLD); end
            end
        end
        exp_cnt++;
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL gaps_vld: got %b want 1", byteStripingVLD); end
        n_cmp++; if (stripedLanes !== 32'h44332211) begin n_fail++; $display("FAIL gaps_lanes: got %h want %h", stripedLanes, 32'h44332211); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL gaps_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
    endtask

    task automatic test_flush();
        step(1'b1, 8'hAA, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'h55, 1'b0, 2'd2, 1'b0);
        step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
        exp_cnt++;
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL flush_vld: got %b want 1", byteStripingVLD); end
        n_cmp++; if (stripedLanes !== 32'hBCBC55AA) begin n_fail++; $display("FAIL flush_lanes: got %h want %h", stripedLanes, 32'hBCBC55AA); end
        n_cmp++; if (laneValidOut !== 4'b0011) begin n_fail++; $display("FAIL flush_mask: got %b want 0011", laneValidOut); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
        // flush with nothing staged does nothing
        step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0);
        n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL flush_empty_vld: got %b want 0", byteStripingVLD); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL flush_empty_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
        // flush together with the first word of a group: one real word
        step(1'b1, 8'h77, 1'b1, 2'd2, 1'b0);
        exp_cnt++;
        n_cmp++; if (stripedLanes !== 32'hBCBCBC77) begin n_fail++; $display("FAIL flush_one_lanes: got %h want %h", stripedLanes, 32'hBCBCBC77); end
        n_cmp++; if (laneValidOut !== 4'b0001) begin n_fail++; $display("FAIL flush_one_mask: got %b want 0001", laneValidOut); end
        // flush together with the completing word: plain full group, no extra
        step(1'b1, 8'h01, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'h02, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'h03, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'h04, 1'b1, 2'd2, 1'b0);
        exp_cnt++;
        n_cmp++; if (stripedLanes !== 32'h04030201) begin n_fail++; $display("FAIL flush_full_lanes: got %h want %h", stripedLanes, 32'h04030201); end
        n_cmp++; if (laneValidOut !== 4'b1111) begin n_fail++; $display("FAIL flush_full_mask: got %b want 1111", laneValidOut); end
        step(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
        n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL flush_full_extra: got %b want 0", byteStripingVLD); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL flush_full_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
    endtask

    task automatic test_mode1();
        step(1'b1, 8'h01, 1'b0, 2'd1, 1'b0);
        n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL m1_early: got %b want 0", byteStripingVLD); end
        step(1'b1, 8'h02, 1'b0, 2'd1, 1'b0);
        exp_cnt++;
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL m1_vld_a: got %b want 1", byteStripingVLD); end
        n_cmp++; if (stripedLanes !== 32'hBCBC0201) begin n_fail++; $display("FAIL m1_lanes_a: got %h want %h", stripedLanes, 32'hBCBC0201); end
        n_cmp++; if (laneValidOut !== 4'b0011) begin n_fail++; $display("FAIL m1_mask_a: got %b want 0011", laneValidOut); end
        step(1'b1, 8'h03, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h04, 1'b0, 2'd1, 1'b0);
        exp_cnt++;
        n_cmp++; if (stripedLanes !== 32'hBCBC0403) begin n_fail++; $display("FAIL m1_lanes_b: got %h want %h", stripedLanes, 32'hBCBC0403); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL m1_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
        // mode change mid-group is ignored until the next group
        step(1'b1, 8'h01, 1'b0, 2'd1, 1'b0);
        step(1'b1, 8'h02, 1'b0, 2'd2, 1'b0);
        exp_cnt++;
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL m1_switch_vld: got %b want 1", byteStripingVLD); end
        n_cmp++; if (laneValidOut !== 4'b0011) begin n_fail++; $display("FAIL m1_switch_mask: got %b want 0011", laneValidOut); end
        // mode 3 clips to the four physical lanes
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'hE0 + i), 1'b0, 2'd3, 1'b0);
        end
        exp_cnt++;
        n_cmp++; if (stripedLanes !== 32'hE3E2E1E0) begin n_fail++; $display("FAIL m3_clip_lanes: got %h want %h", stripedLanes, 32'hE3E2E1E0); end
        n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL m3_clip_vld: got %b want 1", byteStripingVLD); end
    endtask

    task automatic test_reset_mid();
        int strobes;
        step(1'b1, 8'h01, 1'b0, 2'd2, 1'b0);
        step(1'b1, 8'h02, 1'b0, 2'd2, 1'b0);
        step(1'b0, 8'h00, 1'b0, 2'd2, 1'b1);
        exp_cnt = 0;
        n_cmp++; if ({stripedLanes, laneValidOut, byteStripingVLD, groupCnt} !== 39'h0) begin
            n_fail++; $display("FAIL rstmid_zero: got %h/%b/%b/%0d want 0", stripedLanes, laneValidOut, byteStripingVLD, groupCnt);
        end
        strobes = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h0A + i), 1'b0, 2'd2, 1'b0);
            if (byteStripingVLD === 1'b1) strobes++;
        end
        step(1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
        if (byteStripingVLD === 1'b1) strobes++;
        exp_cnt++;
        n_cmp++; if (strobes !== 1) begin n_fail++; $display("FAIL rstmid_strobes: got %0d want 1", strobes); end
        n_cmp++; if (stripedLanes !== 32'h0D0C0B0A) begin n_fail++; $display("FAIL rstmid_lanes: got %h want %h", stripedLanes, 32'h0D0C0B0A); end
        n_cmp++; if (groupCnt !== 2'(exp_cnt)) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want %0d", groupCnt, exp_cnt % 4); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  want_cnt [5];
        logic [31:0] want_lanes;
        want_cnt[0] = 2'd1; want_cnt[1] = 2'd2; want_cnt[2] = 2'd3; want_cnt[3] = 2'd0; want_cnt[4] = 2'd1;
        step(1'b0, 8'h00, 1'b0, 2'd2, 1'b1);
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 8'(g * 16 + i), 1'b0, 2'd2, 1'b0);
                if (i == 0 && g > 0) begin
                    n_cmp++; if (byteStripingVLD !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_vld[%0d]: got %b want 0", g, byteStripingVLD); end
                end
            end
            want_lanes = {8'(g * 16 + 3), 8'(g * 16 + 2), 8'(g * 16 + 1), 8'(g * 16)};
            n_cmp++; if (byteStripingVLD !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d]: got %b want 1", g, byteStripingVLD); end
            n_cmp++; if (stripedLanes !== want_lanes) begin n_fail++; $display("FAIL b2b_lanes[%0d]: got %h want %h", g, stripedLanes, want_lanes); end
            n_cmp++; if (groupCnt !== want_cnt[g]) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", g, groupCnt, want_cnt[g]); end
        end
    endtask

    initial begin
        reset = 1'b1; laneVLD = 1'b0; flushIN = 1'b0; laneMode = 2'd2; byteStripingIN = 8'h00;
        test_reset();
        test_full_group();
        test_gaps();
        test_flush();
        test_mode1();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_byte_striping_param
`default_nettype wire
